// File: rtl/reg_status_file_pkg.sv
// Shared defaults, zero constants and flattened-port slice macros for reg_status_file.
// RF_CMT_BYPASS_EN: forward same-cycle commit values onto operand reads.
`ifndef RSF_SLICE
`define RSF_SLICE(v, i, w) v[(i)*(w) +: (w)]
`endif

package reg_status_file_pkg;

    localparam int RSF_XLEN  = 32;
    localparam int RSF_NREG  = 32;
    localparam int RSF_ROB_W = 4;
    localparam int RSF_REG_W = $clog2(RSF_NREG);

    localparam logic [RSF_REG_W-1:0] ZERO_REG  = '0;
    localparam logic [RSF_ROB_W-1:0] ZERO_ROB  = '0;
    localparam logic [RSF_XLEN-1:0]  ZERO_WORD = '0;

endpackage

// File: rtl/reg_status_file_fwd.sv
// Per-read-port operand forwarding: x0, same-cycle alloc, flush, commit, stored state.
// RF_CMT_BYPASS_EN selects commit-value bypass onto val.
module reg_status_fwd
    import reg_status_file_pkg::*;
#(
    parameter int XLEN  = RSF_XLEN,
    parameter int REG_W = RSF_REG_W,
    parameter int ROB_W = RSF_ROB_W,
    parameter int CMT_W = 2
) (
    input  logic [REG_W-1:0]       idx,
    input  logic [XLEN-1:0]        st_val,
    input  logic                   st_busy,
    input  logic [ROB_W-1:0]       st_tag,
    input  logic                   alloc_en,
    input  logic [REG_W-1:0]       alloc_rd,
    input  logic [ROB_W-1:0]       alloc_tag,
    input  logic                   flush,
    input  logic [CMT_W-1:0]       cmt_en,
    input  logic [CMT_W*REG_W-1:0] cmt_rd,
    input  logic [CMT_W*ROB_W-1:0] cmt_tag,
    input  logic [CMT_W*XLEN-1:0]  cmt_val,
    output logic [XLEN-1:0]        val,
    output logic                   busy,
    output logic [ROB_W-1:0]       tag
);

    logic is_x0;
    logic alloc_hit;
    logic cmt_hit;
    logic [XLEN-1:0] byp_val;

    assign is_x0     = (idx == REG_W'(ZERO_REG));
    assign alloc_hit = alloc_en && (alloc_rd == idx);

    always_comb begin
        cmt_hit = 1'b0;
        for (int c = 0; c < CMT_W; c++) begin
            if (cmt_en[c] && (`RSF_SLICE(cmt_rd, c, REG_W) == idx)
                && (`RSF_SLICE(cmt_tag, c, ROB_W) == st_tag)) begin
                cmt_hit = 1'b1;
            end
        end
    end

`ifdef RF_CMT_BYPASS_EN
    // later port is younger, so it overrides
    always_comb begin
        byp_val = st_val;
        for (int c = 0; c < CMT_W; c++) begin
            if (cmt_en[c] && (`RSF_SLICE(cmt_rd, c, REG_W) == idx)) begin
                byp_val = `RSF_SLICE(cmt_val, c, XLEN);
            end
        end
    end
`else
    assign byp_val = st_val;
`endif

    always_comb begin
        val  = byp_val;
        busy = st_busy;
        tag  = st_tag;
        priority case (1'b1)
            is_x0: begin
                val  = XLEN'(ZERO_WORD);
                busy = 1'b0;
                tag  = ROB_W'(ZERO_ROB);
            end
            alloc_hit: begin
                busy = 1'b1;
                tag  = alloc_tag;
            end
            flush:   busy = 1'b0;
            cmt_hit: busy = 1'b0;
            default: ;
        endcase
    end

endmodule

// File: rtl/reg_status_file.sv
// Architectural register file with busy/ROB-tag rename status and forwarded reads.
// RF_CMT_BYPASS_EN enables commit-value bypass in reg_status_fwd.
module reg_status_file
    import reg_status_file_pkg::*;
#(
    parameter int XLEN     = RSF_XLEN,
    parameter int NREG     = RSF_NREG,
    parameter int REG_W    = $clog2(NREG),
    parameter int ROB_W    = RSF_ROB_W,
    parameter int RD_PORTS = 2,
    parameter int CMT_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic [RD_PORTS*REG_W-1:0] rd_idx,
    output logic [RD_PORTS*XLEN-1:0]  rd_val,
    output logic [RD_PORTS-1:0]       rd_busy,
    output logic [RD_PORTS*ROB_W-1:0] rd_tag,
    input  logic                      alloc_en,
    input  logic [REG_W-1:0]          alloc_rd,
    input  logic [ROB_W-1:0]          alloc_tag,
    input  logic [CMT_W-1:0]          cmt_en,
    input  logic [CMT_W*REG_W-1:0]    cmt_rd,
    input  logic [CMT_W*ROB_W-1:0]    cmt_tag,
    input  logic [CMT_W*XLEN-1:0]     cmt_val,
    input  logic                      flush,
    output logic [$clog2(NREG+1)-1:0] busy_cnt
);

    localparam int CNT_W = $clog2(NREG+1);

    logic [XLEN-1:0]  v_q [NREG];
    logic [XLEN-1:0]  v_d [NREG];
    logic [ROB_W-1:0] t_q [NREG];
    logic [ROB_W-1:0] t_d [NREG];
    logic [NREG-1:0]  b_q;
    logic [NREG-1:0]  b_d;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        logic [REG_W-1:0] rd;
        rd  = '0;
        v_d = v_q;
        t_d = t_q;
        b_d = b_q;
        for (int c = 0; c < CMT_W; c++) begin
            rd = `RSF_SLICE(cmt_rd, c, REG_W);
            if (cmt_en[c] && rd != REG_W'(ZERO_REG)) begin
                v_d[rd] = `RSF_SLICE(cmt_val, c, XLEN);
                if (b_q[rd] && t_q[rd] == `RSF_SLICE(cmt_tag, c, ROB_W)) begin
                    b_d[rd] = 1'b0;
                end
            end
        end
        // flush drops every pending rename, including this cycle's alloc
        if (flush) begin
            b_d = '0;
        end else if (alloc_en && alloc_rd != REG_W'(ZERO_REG)) begin
            b_d[alloc_rd] = 1'b1;
            t_d[alloc_rd] = alloc_tag;
        end
    end

    always_comb begin
        cnt_d = '0;
        for (int r = 0; r < NREG; r++) begin
            cnt_d = cnt_d + CNT_W'(b_d[r]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                v_q[r] <= '0;
                t_q[r] <= '0;
            end
            b_q      <= '0;
            busy_cnt <= '0;
        end else if (rdy) begin
            v_q      <= v_d;
            t_q      <= t_d;
            b_q      <= b_d;
            busy_cnt <= cnt_d;
        end
    end

    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
        logic [REG_W-1:0] idx;
        assign idx = `RSF_SLICE(rd_idx, p, REG_W);

        reg_status_fwd #(
            .XLEN (XLEN),
            .REG_W(REG_W),
            .ROB_W(ROB_W),
            .CMT_W(CMT_W)
        ) u_fwd (
            .idx      (idx),
            .st_val   (v_q[idx]),
            .st_busy  (b_q[idx]),
            .st_tag   (t_q[idx]),
            .alloc_en (alloc_en),
            .alloc_rd (alloc_rd),
            .alloc_tag(alloc_tag),
            .flush    (flush),
            .cmt_en   (cmt_en),
            .cmt_rd   (cmt_rd),
            .cmt_tag  (cmt_tag),
            .cmt_val  (cmt_val),
            .val      (`RSF_SLICE(rd_val, p, XLEN)),
            .busy     (rd_busy[p]),
            .tag      (`RSF_SLICE(rd_tag, p, ROB_W))
        );
    end

endmodule

// File: tb/tb_reg_status_file.sv
// Directed table-driven bench for reg_status_file (2 read ports, 2 commit ports).
// Value expectations follow RF_CMT_BYPASS_EN when it is defined.
module tb_reg_status_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [9:0]  rd_idx;
    logic [63:0] rd_val;
    logic [1:0]  rd_busy;
    logic [7:0]  rd_tag;
    logic        alloc_en;
    logic [4:0]  alloc_rd;
    logic [3:0]  alloc_tag;
    logic [1:0]  cmt_en;
    logic [9:0]  cmt_rd;
    logic [7:0]  cmt_tag;
    logic [63:0] cmt_val;
    logic        flush;
    logic [5:0]  busy_cnt;

    int n_vec = 0;
    int n_bad = 0;

`ifdef RF_CMT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    always #5 clk = ~clk;

    reg_status_file dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .rd_idx   (rd_idx),
        .rd_val   (rd_val),
        .rd_busy  (rd_busy),
        .rd_tag   (rd_tag),
        .alloc_en (alloc_en),
        .alloc_rd (alloc_rd),
        .alloc_tag(alloc_tag),
        .cmt_en   (cmt_en),
        .cmt_rd   (cmt_rd),
        .cmt_tag  (cmt_tag),
        .cmt_val  (cmt_val),
        .flush    (flush),
        .busy_cnt (busy_cnt)
    );

    typedef struct {
        int unsigned rst, rdy, a_en, a_rd, a_tag;
        int unsigned c_en, c0_rd, c0_tag, c0_val, c1_rd, c1_tag, c1_val;
        int unsigned flush, r0, r1;
        int unsigned e0_val, e0_busy, e0_tag;
        int unsigned e1_val, e1_busy, e1_tag;
        int unsigned e_cnt;
    } vec_t;

    function automatic int unsigned byp(int unsigned nv, int unsigned ov);
        return BYP ? nv : ov;
    endfunction

    task automatic drive(input vec_t t);
        rst       = 1'(t.rst);
        rdy       = 1'(t.rdy);
        alloc_en  = 1'(t.a_en);
        alloc_rd  = 5'(t.a_rd);
        alloc_tag = 4'(t.a_tag);
        cmt_en    = 2'(t.c_en);
        cmt_rd    = {5'(t.c1_rd), 5'(t.c0_rd)};
        cmt_tag   = {4'(t.c1_tag), 4'(t.c0_tag)};
        cmt_val   = {32'(t.c1_val), 32'(t.c0_val)};
        flush     = 1'(t.flush);
        rd_idx    = {5'(t.r1), 5'(t.r0)};
    endtask

    task automatic cmp(input string name, input int unsigned got,
                       input int unsigned exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, need %0h", name, got, exp);
        end
    endtask

    vec_t tv [28];
    vec_t idle;

    initial begin
        idle = '{0,1,0,0,0, 0,0,0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0, 0};
        // rst rdy aen ard atag | cen c0rd c0tag c0val c1rd c1tag c1val | fl r0 r1 | e0 val busy tag | e1 val busy tag | cnt
        tv[0]  = '{0,1,0,0,0, 0,0,0,0,0,0,0, 0,5,0, 0,0,0, 0,0,0, 0};
        tv[1]  = '{0,1,1,5,3, 0,0,0,0,0,0,0, 0,5,0, 0,1,3, 0,0,0, 0};
        tv[2]  = '{0,1,0,0,0, 0,0,0,0,0,0,0, 0,5,6, 0,1,3, 0,0,0, 1};
        tv[3]  = '{0,1,0,0,0, 1,5,3,'hDEAD,0,0,0, 0,5,5,
                   byp('hDEAD,0),0,0, byp('hDEAD,0),0,0, 1};
        tv[4]  = '{0,1,0,0,0, 0,0,0,0,0,0,0, 0,5,7, 'hDEAD,0,0, 0,0,0, 0};
        tv[5]  = '{0,1,1,7,2, 0,0,0,0,0,0,0, 0,7,5, 0,1,2, 'hDEAD,0,0, 0};
        tv[6]  = '{0,1,1,7,6, 0,0,0,0,0,0,0, 0,7,5, 0,1,6, 'hDEAD,0,0, 1};
        tv[7]  = '{0,1,0,0,0, 1,7,2,9,0,0,0, 0,7,7,
                   byp(9,0),1,6, byp(9,0),1,6, 1};
        tv[8]  = '{0,1,0,0,0, 0,0,0,0,0,0,0, 0,7,8, 9,1,6, 0,0,0, 1};
        tv[9]  = '{0,1,1,8,5, 0,0,0,0,0,0,0, 0,8,0, 0,1,5, 0,0,0, 1};
        tv[10] = '{0,1,0,0,0, 3,8,4,1,8,5,2, 0,8,8,
                   byp(2,0),0,0, byp(2,0),0,0, 2};
        tv[11] = '{0,1,0,0,0, 0,0,0,0,0,0,0, 0,8,7, 2,0,0, 9,1,6, 1};
        tv[12] = '{0,1,1,3,7, 0,0,0,0,0,0,0, 0,3,0, 0,1,7, 0,0,0, 1};
        tv[13] = '{0,1,1,9,8, 0,0,0,0,0,0,0, 0,9,3, 0,1,8, 0,1,7, 2};
        tv[14] = '{0,1,0,0,0, 0,0,0,0,0,0,0, 0,7,9, 9,1,6, 0,1,8, 3};
        tv[15] = '{0,1,1,4,1, 1,3,7,'h10,0,0,0, 1,3,9,
                   byp('h10,0),0,0, 0,0,0, 3};
        tv[16] = '{0,1,0,0,0, 0,0,0,0,0,0,0, 0,4,3, 0,0,0, 'h10,0,0, 0};
        tv[17] = '{0,1,1,0,5, 3,0,0,'h55,0,0,'h66, 0,0,0, 0,0,0, 0,0,0, 0};
        tv[18] = '{0,1,0,0,0, 0,0,0,0,0,0,0, 0,0,4, 0,0,0, 0,0,0, 0};
        tv[19] = '{0,0,1,6,2, 0,0,0,0,0,0,0, 0,6,0, 0,1,2, 0,0,0, 0};
        tv[20] = '{0,1,0,0,0, 0,0,0,0,0,0,0, 0,6,0, 0,0,0, 0,0,0, 0};
        tv[21] = '{0,0,0,0,0, 1,3,0,'h77,0,0,0, 0,3,0,
                   byp('h77,'h10),0,0, 0,0,0, 0};
        tv[22] = '{0,1,0,0,0, 0,0,0,0,0,0,0, 0,3,0, 'h10,0,0, 0,0,0, 0};
        tv[23] = '{0,1,1,11,3, 0,0,0,0,0,0,0, 0,11,0, 0,1,3, 0,0,0, 0};
        tv[24] = '{0,1,1,11,4, 1,11,3,5,0,0,0, 0,11,11,
                   byp(5,0),1,4, byp(5,0),1,4, 1};
        tv[25] = '{0,1,0,0,0, 0,0,0,0,0,0,0, 0,11,0, 5,1,4, 0,0,0, 1};
        tv[26] = '{1,1,1,12,1, 0,0,0,0,0,0,0, 0,11,12, 5,1,4, 0,1,1, 1};
        tv[27] = '{0,1,0,0,0, 0,0,0,0,0,0,0, 0,11,5, 0,0,0, 0,0,0, 0};

        drive(idle);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 28; i++) begin
            bit ok;
            @(negedge clk);
            drive(tv[i]);
            #2;
            ok = (rd_val[31:0]  === 32'(tv[i].e0_val))
              && (rd_busy[0]    === 1'(tv[i].e0_busy))
              && (tv[i].e0_busy == 0 || rd_tag[3:0] === 4'(tv[i].e0_tag))
              && (rd_val[63:32] === 32'(tv[i].e1_val))
              && (rd_busy[1]    === 1'(tv[i].e1_busy))
              && (tv[i].e1_busy == 0 || rd_tag[7:4] === 4'(tv[i].e1_tag))
              && (busy_cnt      === 6'(tv[i].e_cnt));
            n_vec++;
            if (!ok) begin
                n_bad++;
                $display("FAIL vec%0d: got p0 %h/%0d/%0d p1 %h/%0d/%0d cnt %0d, need p0 %h/%0d/%0d p1 %h/%0d/%0d cnt %0d",
                         i, rd_val[31:0], rd_busy[0], rd_tag[3:0],
                         rd_val[63:32], rd_busy[1], rd_tag[7:4], busy_cnt,
                         tv[i].e0_val, tv[i].e0_busy, tv[i].e0_tag,
                         tv[i].e1_val, tv[i].e1_busy, tv[i].e1_tag, tv[i].e_cnt);
            end
        end

        // held flush under rdy low must not clear state until rdy returns
        @(negedge clk);
        drive(idle);
        alloc_en  = 1'b1;
        alloc_rd  = 5'd20;
        alloc_tag = 4'd1;
        @(negedge clk);
        drive(idle);
        rd_idx = {5'd0, 5'd20};
        #2;
        cmp("alloc_x20_busy", 32'(rd_busy[0]), 1);
        cmp("alloc_x20_cnt", 32'(busy_cnt), 1);
        rdy   = 1'b0;
        flush = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #2;
            cmp("hold_cnt", 32'(busy_cnt), 1);
            cmp("hold_flush_fwd", 32'(rd_busy[0]), 0);
        end
        @(negedge clk);
        rdy = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #2;
        cmp("flush_cnt", 32'(busy_cnt), 0);
        cmp("flush_x20_busy", 32'(rd_busy[0]), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
